// File: rtl/mdu_unit.sv
// +--------------------------------------------------------------------------+
// | mdu_unit: multi-cycle MULT/DIV unit that owns HI/LO for the EX stage.    |
// | Optional MADD/MSUB accumulate ops when MDU_MADD_EN is defined.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nx;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [3:0]         op_q;
    logic               op_is_mdu;
    logic               op_is_div;
    logic               accept;
    logic               done;

    always_comb begin
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        op_is_mdu = (op <= OP_DIVU) || ((op >= OP_MADD) && (op <= OP_MSUBU));
`else
        op_is_mdu = (op <= OP_DIVU);
`endif
        accept = (state == ST_IDLE) && start && op_is_mdu;
    end

    // Counter is loaded with N-1 so busy stays high for exactly N cycles.
    always_comb begin
        state_nx = state;
        count_nx = count;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_BUSY;
                    count_nx = op_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                end
            end
            ST_BUSY: begin
                if (count == '0) begin
                    state_nx = ST_IDLE;
                    done     = 1'b1;
                end else begin
                    count_nx = count - CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    assign busy = (state == ST_BUSY);

    logic        mul_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] hilo_nx;

    // Low 64 bits of the sign/zero-extended product give the exact 32x32 result.
    always_comb begin
`ifdef MDU_MADD_EN
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
`else
        mul_signed = (op_q == OP_MULT);
`endif
        ext_a   = mul_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b   = mul_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        product = ext_a * ext_b;
    end

    // Sign-magnitude division keeps 0x80000000 / -1 well defined (quotient wraps).
    always_comb begin
        div_signed = (op_q == OP_DIV);
        neg_a      = div_signed && a_q[31];
        neg_b      = div_signed && b_q[31];
        mag_a      = neg_a ? (~a_q + 32'd1) : a_q;
        mag_b      = neg_b ? (~b_q + 32'd1) : b_q;
        uquot      = mag_a / mag_b;
        urem       = mag_a % mag_b;
        quot       = (neg_a ^ neg_b) ? (~uquot + 32'd1) : uquot;
        rem        = neg_a ? (~urem + 32'd1) : urem;
    end

    always_comb begin
        hilo_nx = {hi, lo};
        case (op_q)
            OP_MULT, OP_MULTU: hilo_nx = product;
            OP_DIV, OP_DIVU: begin
                if (b_q != 32'd0) begin
                    hilo_nx = {rem, quot};
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: hilo_nx = {hi, lo} + product;
            OP_MSUB, OP_MSUBU: hilo_nx = {hi, lo} - product;
`endif
            default: hilo_nx = {hi, lo};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi   <= '0;
            lo   <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= rs_val;
                b_q  <= rt_val;
                op_q <= op;
            end
            if (done) begin
                {hi, lo} <= hilo_nx;
            end else if ((state == ST_IDLE) && !start && (op == OP_MTHI)) begin
                hi <= rs_val;
            end else if ((state == ST_IDLE) && !start && (op == OP_MTLO)) begin
                lo <= rs_val;
            end
        end
    end

    always_comb begin
        case (op)
            OP_MFHI: mdu_result = hi;
            OP_MFLO: mdu_result = lo;
            default: mdu_result = 32'd0;
        endcase
    end

endmodule

`default_nettype wire
